// File: rtl/nfca_rx_ascii_formatter_if.sv
// Bundle between the NFC-A receive stream, the ASCII formatter and the UART-side consumer.
// slave = formatter side, master = the environment driving it.
interface nfca_rx_ascii_formatter_if;
  logic       rx_tvalid;
  logic [7:0] rx_tdata;
  logic [3:0] rx_tdatab;
  logic       rx_tend;
  logic       rx_terr;
  logic       o_tvalid;
  logic       o_tready;
  logic [7:0] o_tdata;
  logic       o_overflow;

  modport slave (
    input  rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr, o_tready,
    output o_tvalid, o_tdata, o_overflow
  );

  modport master (
    output rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr, o_tready,
    input  o_tvalid, o_tdata, o_overflow
  );
endinterface

// File: rtl/nfca_rx_ascii_formatter.sv
// Turns received NFC-A frame items into ASCII hex text: "HL " per byte, "HL:B" per partial byte,
// "\n" per end marker ("n\n" on error). Items are buffered in a FIFO since the source cannot stall.
module nfca_rx_ascii_formatter #(
  parameter int FIFO_EA = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  nfca_rx_ascii_formatter_if.slave   bus
);

  localparam int DEPTH = 1 << FIFO_EA;
  localparam logic [FIFO_EA:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_SEP, S_BITS, S_ERR, S_NL
  } state_t;

  // entry = {tend, terr, tdatab[3:0], tdata[7:0]}
  logic [13:0]      r_mem [DEPTH];
  logic [FIFO_EA:0] r_wptr, r_rptr;
  logic [13:0]      w_ent;
  logic             w_full, w_empty, w_push, w_pop, w_acc, w_last, w_partial;

  state_t     r_state;
  logic [3:0] r_lo;
  logic [3:0] r_bits;
  logic       r_tvalid;
  logic [7:0] r_tdata;
  logic       r_overflow;

  function automatic logic [7:0] f_hex(input logic [3:0] v);
    return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
  endfunction

  assign w_full    = (r_wptr[FIFO_EA] != r_rptr[FIFO_EA]) &&
                     (r_wptr[FIFO_EA-1:0] == r_rptr[FIFO_EA-1:0]);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_ent     = r_mem[r_rptr[FIFO_EA-1:0]];
  assign w_acc     = r_tvalid & bus.o_tready;
  assign w_partial = ~r_bits[3];
  assign w_last    = ((r_state == S_SEP) & ~w_partial) | (r_state == S_BITS) | (r_state == S_NL);
  // Next entry pops either from idle or on acceptance of the current entry's last character
  assign w_pop     = ~w_empty & ((r_state == S_IDLE) | (w_acc & w_last));
  assign w_push    = bus.rx_tvalid & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_EA-1:0]] <= {bus.rx_tend, bus.rx_terr, bus.rx_tdatab, bus.rx_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_state    <= S_IDLE;
      r_lo       <= '0;
      r_bits     <= '0;
      r_tvalid   <= 1'b0;
      r_tdata    <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.rx_tvalid & w_full & ~w_pop;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) begin
        r_rptr   <= r_rptr + PTR_ONE;
        r_lo     <= w_ent[3:0];
        r_bits   <= w_ent[11:8];
        r_tvalid <= 1'b1;
        if (w_ent[13]) begin
          r_state <= w_ent[12] ? S_ERR : S_NL;
          r_tdata <= w_ent[12] ? 8'h6E : 8'h0A;
        end else begin
          r_state <= S_HI;
          r_tdata <= f_hex(w_ent[7:4]);
        end
      end else if (w_acc) begin
        case (r_state)
          S_HI: begin
            r_state <= S_LO;
            r_tdata <= f_hex(r_lo);
          end
          S_LO: begin
            r_state <= S_SEP;
            r_tdata <= w_partial ? 8'h3A : 8'h20;
          end
          S_SEP: begin
            if (w_partial) begin
              r_state <= S_BITS;
              r_tdata <= f_hex(r_bits);
            end else begin
              r_state  <= S_IDLE;
              r_tvalid <= 1'b0;
            end
          end
          S_ERR: begin
            r_state <= S_NL;
            r_tdata <= 8'h0A;
          end
          default: begin
            r_state  <= S_IDLE;
            r_tvalid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_tvalid   = r_tvalid;
  assign bus.o_tdata    = r_tdata;
  assign bus.o_overflow = r_overflow;

endmodule
